// File: rtl/run_detector_pkg.sv
// rtl/run_detector_pkg.sv - shared types and constants for the run detector
// Contents:
//   state_t : IDLE (no sample since reset/clear), RUN0 (zeros), RUN1 (ones)
//   STATS_W : width of the optional hit statistics counters
package run_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/run_detector_if.sv
// rtl/run_detector_if.sv - sample/result bundle between a bit-stream driver and the run detector
// Parameter: CNT_W  width of run_len
// Signals:
//   en, clear, x          : driver -> detector (sample qualifier, restart, data bit)
//   y, y_zero, y_one, hit : detector -> driver (detection levels and hit pulse)
//   run_len               : detector -> driver (current run length, saturating)
//   zero_hits, one_hits   : detector -> driver, present only with RUN_DETECTOR_STATS_EN
// Modports: master (driver side), slave (detector side)
interface run_detector_if #(
    parameter int CNT_W = 4
);
    import run_detector_pkg::*;

    logic             en;
    logic             clear;
    logic             x;
    logic             y;
    logic             y_zero;
    logic             y_one;
    logic             hit;
    logic [CNT_W-1:0] run_len;

`ifdef RUN_DETECTOR_STATS_EN
    logic [STATS_W-1:0] zero_hits;
    logic [STATS_W-1:0] one_hits;

    modport master (
        output en, clear, x,
        input  y, y_zero, y_one, hit, run_len, zero_hits, one_hits
    );

    modport slave (
        input  en, clear, x,
        output y, y_zero, y_one, hit, run_len, zero_hits, one_hits
    );
`else
    modport master (
        output en, clear, x,
        input  y, y_zero, y_one, hit, run_len
    );

    modport slave (
        input  en, clear, x,
        output y, y_zero, y_one, hit, run_len
    );
`endif

endinterface

// File: rtl/run_detector_sat_counter.sv
// rtl/run_detector_sat_counter.sv - saturating up-counter with clear and load-one
// Parameter: W  counter width
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, count -> 0
//   clr   : synchronous clear to 0 (highest priority)
//   load1 : synchronous load of 1
//   inc   : increment, holds at all-ones
//   q     : count
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load1) begin
            q <= W'(1);
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - consecutive-run detector for a qualified serial bit stream
// Parameters:
//   ZERO_RUN : zero-run threshold, 1 .. 2**CNT_W-1
//   ONE_RUN  : one-run threshold, 1 .. 2**CNT_W-1
//   CNT_W    : run-length counter width
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : run_detector_if.slave (en/clear/x in; y/y_zero/y_one/hit/run_len out)
// Optional feature macro RUN_DETECTOR_STATS_EN adds saturating zero_hits/one_hits
// counters on the interface, cleared by reset and clear.
module run_detector #(
    parameter int ZERO_RUN = 3,
    parameter int ONE_RUN  = 3,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    run_detector_if.slave  bus
);
    import run_detector_pkg::*;

    localparam logic [CNT_W-1:0] ZERO_THR = CNT_W'(ZERO_RUN);
    localparam logic [CNT_W-1:0] ONE_THR  = CNT_W'(ONE_RUN);

    state_t           state;
    state_t           state_next;
    logic             hit_q;
    logic             hit_next;
    logic             same_bit;
    logic             len_load1;
    logic             len_inc;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] len_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hit_q <= 1'b0;
        end else begin
            state <= state_next;
            hit_q <= hit_next;
        end
    end

    // len_next mirrors what the counter will hold after this edge so the hit
    // pulse can be registered in the same cycle the threshold is reached.
    always_comb begin
        state_next = state;
        hit_next   = 1'b0;
        same_bit   = 1'b0;
        len_load1  = 1'b0;
        len_inc    = 1'b0;
        len_next   = run_len;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.en) begin
            case (state)
                RUN0:    same_bit = !bus.x;
                RUN1:    same_bit = bus.x;
                default: same_bit = 1'b0;
            endcase
            if (same_bit) begin
                len_inc  = 1'b1;
                len_next = (&run_len) ? run_len : run_len + CNT_W'(1);
            end else begin
                len_load1  = 1'b1;
                len_next   = CNT_W'(1);
                state_next = bus.x ? RUN1 : RUN0;
            end
            // A saturated run leaves both length and state unchanged, which
            // keeps a threshold of 2**CNT_W-1 from re-firing every sample.
            hit_next = ((len_next != run_len) || (state_next != state)) &&
                       (len_next == (bus.x ? ONE_THR : ZERO_THR));
        end
    end

    sat_counter #(.W(CNT_W)) u_run_len (
        .clk   (clk),
        .rst   (reset),
        .clr   (bus.clear),
        .load1 (len_load1),
        .inc   (len_inc),
        .q     (run_len)
    );

    assign bus.run_len = run_len;
    assign bus.y_zero  = (state == RUN0) && (run_len >= ZERO_THR);
    assign bus.y_one   = (state == RUN1) && (run_len >= ONE_THR);
    assign bus.y       = bus.y_zero | bus.y_one;
    assign bus.hit     = hit_q;

`ifdef RUN_DETECTOR_STATS_EN
    // Counted on hit_next so the statistics move on the same edge as hit.
    sat_counter #(.W(STATS_W)) u_zero_hits (
        .clk   (clk),
        .rst   (reset),
        .clr   (bus.clear),
        .load1 (1'b0),
        .inc   (hit_next && (state_next == RUN0)),
        .q     (bus.zero_hits)
    );

    sat_counter #(.W(STATS_W)) u_one_hits (
        .clk   (clk),
        .rst   (reset),
        .clr   (bus.clear),
        .load1 (1'b0),
        .inc   (hit_next && (state_next == RUN1)),
        .q     (bus.one_hits)
    );
`endif

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - self-checking bench for run_detector (three threshold configurations)
module tb_run_detector;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    run_detector_if #(.CNT_W(4)) bus_a ();
    run_detector_if #(.CNT_W(3)) bus_b ();
    run_detector_if #(.CNT_W(4)) bus_c ();

    run_detector #(.ZERO_RUN(3), .ONE_RUN(3), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    run_detector #(.ZERO_RUN(5), .ONE_RUN(2), .CNT_W(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    run_detector #(.ZERO_RUN(1), .ONE_RUN(1), .CNT_W(4)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    int errors = 0;
    int checks = 0;

    // Reference model: every accepted bit since the last reset/clear.
    int zr[3]   = '{3, 5, 1};
    int orr[3]  = '{3, 2, 1};
    int maxv[3] = '{15, 7, 15};
    bit hist[$];
    bit mhit[3];
    int zh[3];
    int oh[3];
    bit cur_x;

    function automatic int trail();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_vec(input int k);
        int  raw;
        int  len;
        bit  b;
        bit  yz;
        bit  yo;
        raw = trail();
        len = (raw > maxv[k]) ? maxv[k] : raw;
        b   = (hist.size() > 0) ? hist[hist.size() - 1] : 1'b0;
        yz  = (hist.size() > 0) && (b == 1'b0) && (raw >= zr[k]);
        yo  = (hist.size() > 0) && (b == 1'b1) && (raw >= orr[k]);
        return {yz | yo, yz, yo, mhit[k], 4'(len)};
    endfunction

    function automatic logic [7:0] obs(input int k);
        case (k)
            0:       return {bus_a.y, bus_a.y_zero, bus_a.y_one, bus_a.hit, bus_a.run_len};
            1:       return {bus_b.y, bus_b.y_zero, bus_b.y_one, bus_b.hit, 1'b0, bus_b.run_len};
            default: return {bus_c.y, bus_c.y_zero, bus_c.y_one, bus_c.hit, bus_c.run_len};
        endcase
    endfunction

`ifdef RUN_DETECTOR_STATS_EN
    function automatic logic [31:0] obs_stats(input int k);
        case (k)
            0:       return {bus_a.zero_hits, bus_a.one_hits};
            1:       return {bus_b.zero_hits, bus_b.one_hits};
            default: return {bus_c.zero_hits, bus_c.one_hits};
        endcase
    endfunction
`endif

    task automatic model_restart();
        hist.delete();
        for (int k = 0; k < 3; k++) begin
            mhit[k] = 1'b0;
            zh[k]   = 0;
            oh[k]   = 0;
        end
    endtask

    task automatic model_update(input bit en, input bit clr, input bit x);
        int raw;
        if (clr) begin
            model_restart();
        end else if (en) begin
            hist.push_back(x);
            if (hist.size() > 40) void'(hist.pop_front());
            raw = trail();
            for (int k = 0; k < 3; k++) begin
                mhit[k] = (raw == (x ? orr[k] : zr[k]));
                if (mhit[k] && x && oh[k] < 65535) oh[k]++;
                if (mhit[k] && !x && zh[k] < 65535) zh[k]++;
            end
        end else begin
            for (int k = 0; k < 3; k++) mhit[k] = 1'b0;
        end
    endtask

    task automatic drive(input bit en, input bit clr, input bit x);
        bus_a.en = en; bus_a.clear = clr; bus_a.x = x;
        bus_b.en = en; bus_b.clear = clr; bus_b.x = x;
        bus_c.en = en; bus_c.clear = clr; bus_c.x = x;
    endtask

    task automatic step(input bit en, input bit clr, input bit x);
        @(negedge clk);
        drive(en, clr, x);
        @(posedge clk);
        #1;
        model_update(en, clr, x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        model_restart();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 8'h00) begin
                errors++;
                $display("FAIL reset dut%0d: got %b expected %b", k, obs(k), 8'h00);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_run();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL zero_run[%0d] dut%0d: got %b expected %b", i, k, obs(k), exp_vec(k));
                end
            end
            if (i == 2) begin
                checks++;
                if (obs(0) !== 8'b1101_0011) begin
                    errors++;
                    $display("FAIL zero_run_detect: got %b expected %b", obs(0), 8'b1101_0011);
                end
            end
            if (i == 3) begin
                checks++;
                if (obs(0) !== 8'b1100_0100) begin
                    errors++;
                    $display("FAIL zero_run_after: got %b expected %b", obs(0), 8'b1100_0100);
                end
            end
        end
    endtask

    task automatic test_one_run();
        bit xs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, xs[i]);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL one_run[%0d] dut%0d: got %b expected %b", i, k, obs(k), exp_vec(k));
                end
            end
            if (i == 4) begin
                checks++;
                if (bus_a.y !== 1'b0) begin
                    errors++;
                    $display("FAIL one_run_early_y: got %b expected 0", bus_a.y);
                end
            end
            if (i == 5) begin
                checks++;
                if (obs(0) !== 8'b1011_0011) begin
                    errors++;
                    $display("FAIL one_run_detect: got %b expected %b", obs(0), 8'b1011_0011);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int hits = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus_b.hit === 1'b1) hits++;
            checks++;
            if (obs(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL sat[%0d] dut1: got %b expected %b", i, obs(1), exp_vec(1));
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (bus_b.y_zero !== (i == 4)) begin
                    errors++;
                    $display("FAIL sat_yzero[%0d]: got %b expected %b", i, bus_b.y_zero, (i == 4));
                end
            end
        end
        checks++;
        if (bus_b.run_len !== 3'd7) begin
            errors++;
            $display("FAIL sat_len: got %0d expected 7", bus_b.run_len);
        end
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL sat_hits: got %0d expected 1", hits);
        end
    endtask

    task automatic test_en_gating();
        bit ens[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(ens[i], 1'b0, ens[i] ? 1'b0 : 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL en_gate[%0d] dut%0d: got %b expected %b", i, k, obs(k), exp_vec(k));
                end
            end
            if (i >= 3) begin
                checks++;
                if (obs(0) !== ((i == 3) ? 8'b0000_0010 : (i == 4) ? 8'b1101_0011 : 8'b1100_0011)) begin
                    errors++;
                    $display("FAIL en_gate_const[%0d]: got %b", i, obs(0));
                end
            end
        end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus_a.y_one !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: got y_one=%b expected 1", bus_a.y_one);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs(0) !== 8'h00) begin
            errors++;
            $display("FAIL clear_wins: got %b expected %b", obs(0), 8'h00);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (obs(0) !== 8'b0000_0001) begin
            errors++;
            $display("FAIL clear_restart: got %b expected %b", obs(0), 8'b0000_0001);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL clear_model dut%0d: got %b expected %b", k, obs(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 8'h00) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %b expected %b", k, obs(k), 8'h00);
            end
        end
        model_restart();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL post_reset dut%0d: got %b expected %b", k, obs(k), exp_vec(k));
            end
        end
    endtask

`ifdef RUN_DETECTOR_STATS_EN
    task automatic test_stats();
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus_a.zero_hits, bus_a.one_hits} !== {16'd2, 16'd0}) begin
            errors++;
            $display("FAIL stats_two_runs: got %0d/%0d expected 2/0", bus_a.zero_hits, bus_a.one_hits);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_stats(k) !== {16'(zh[k]), 16'(oh[k])}) begin
                errors++;
                $display("FAIL stats_model dut%0d: got %h expected %h", k, obs_stats(k), {16'(zh[k]), 16'(oh[k])});
            end
        end
    endtask
`endif

    task automatic test_random();
        bit en;
        bit clr;
        cur_x = 1'b0;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) cur_x = ~cur_x;
            step(en, clr, cur_x);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d: got %b expected %b", i, k, obs(k), exp_vec(k));
                end
`ifdef RUN_DETECTOR_STATS_EN
                checks++;
                if (obs_stats(k) !== {16'(zh[k]), 16'(oh[k])}) begin
                    errors++;
                    $display("FAIL random_stats[%0d] dut%0d: got %h expected %h", i, k, obs_stats(k), {16'(zh[k]), 16'(oh[k])});
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_one_run();
        test_saturation();
        test_en_gating();
        test_clear();
        test_async_reset();
`ifdef RUN_DETECTOR_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
